alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  EX->MEM pipeline stage directly downstream of the 64-bit adder.
//  Registers sum/overflow/cout with destination info under a valid/ready handshake.
//  Derives NZCV and holds the architectural flag register for B.cond.
//  Supports flush from branch resolution.
// PARAMETERS
//  WIDTH    64  datapath width of sum / result
//  REG_BITS 5   destination register index width
// PORTS
//  clk           in   1         rising-edge clock
//  reset_n       in   1         async active-low reset
//  in_valid      in   1         EX presents a result this cycle
//  in_ready      out  1         stage can accept (= !out_valid | out_ready)
//  sum           in   WIDTH     adder sum
//  overflow      in   1         adder signed overflow (V)
//  cout          in   1         adder carry out (C)
//  set_flags     in   1         instruction is flag-setting (ADDS/SUBS)
//  rd_in         in   REG_BITS  destination register
//  reg_write_in  in   1         instruction writes rd
//  flush         in   1         kill held and incoming entry
//  out_valid     out  1         registered entry valid toward MEM
//  out_ready     in   1         MEM accepts this cycle
//  result        out  WIDTH     registered sum
//  rd_out        out  REG_BITS  registered rd
//  reg_write_out out  1         registered write enable (0 when !out_valid)
//  flags         out  4         NZCV {N,Z,C,V}
// BEHAVIOUR
//  - Reset (async, reset_n=0): out_valid=0, result=0, rd_out=0, reg_write_out=0, flags=4'b0000.
//  - Latency: 1 cycle; accept when in_valid & in_ready, data visible next edge.
//  - in_ready = !out_valid | out_ready (combinational, no bubble on full throughput).
//  - Hold: out_valid & !out_ready -> all outputs stable, no new capture.
//  - Drain: out_valid & out_ready & !(in_valid&in_ready) -> out_valid=0 next edge.
//  - Flag calc at accept: N=sum[WIDTH-1], Z=(sum==0), C=cout, V=overflow.
//  - flags updates on the accepting edge only if set_flags=1; else retained.
//  - flush=1: out_valid=0 next edge, incoming not accepted, flags NOT updated by the
//    incoming instruction; flags already committed are kept. flush beats in_valid.
//  - reg_write_out forced 0 whenever out_valid=0.
//  - Reset mid-hold: entry discarded, flags cleared; first edge after release is idle.
//  - Simultaneous drain+accept: new entry replaces old, out_valid stays 1.
//  - States (implicit): EMPTY(out_valid=0) / FULL(out_valid=1); EMPTY->FULL on accept,
//    FULL->EMPTY on drain or flush, FULL->FULL on hold or drain+accept.
// CONFIGURATION
//  FLAG_BYPASS_EN defined: flags output = newly computed NZCV when an accepting,
//    non-flushed set_flags instruction is present this cycle (combinational bypass,
//    lets B.cond in ID resolve a cycle earlier); otherwise the flag register.
//  FLAG_BYPASS_EN undefined: flags output = flag register only (1-cycle visibility).
// TESTING
//  1 reset_n=0 mid-hold, then release -> out_valid=0, result=0, flags=0000.
//  2 sum=64'h0, cout=1, ovf=0, set_flags=1, accept -> next edge result=0, flags=0110.
//  3 sum=64'h8000_0000_0000_0000, ovf=1, set_flags=1, then second op set_flags=0
//    sum=5 -> flags=1001 persists, result=5.
//  4 out_valid=1, out_ready=0, in_valid=1 for 3 cycles -> in_ready=0, result unchanged;
//    out_ready=1 -> new entry captured same edge, out_valid stays 1.
//  5 flush=1 with in_valid=1 set_flags=1 sum=0 -> out_valid=0, flags unchanged.
//  6 FLAG_BYPASS_EN: accept set_flags sum=-1 -> flags=1000 same cycle; undefined -> next cycle.

Source files
------------

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// EX->MEM pipeline register placed directly after the 64-bit adder. It holds
// one result entry under a valid/ready handshake. It derives NZCV from the adder
// outputs and keeps the architectural flag register used by B.cond.
//
// Configuration macro:
//   FLAG_BYPASS_EN  When defined, the flags output shows the NZCV of an
//                   accepting, non-flushed, flag-setting instruction in the
//                   same cycle. The flag register is used otherwise.
//                   When undefined, flags always come from the register, so a
//                   new value becomes visible one cycle after the accept.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   in_valid      EX presents a result this cycle
//   in_ready      stage can accept (= !out_valid | out_ready)
//   sum           adder sum, WIDTH bits
//   overflow      adder signed overflow (V)
//   cout          adder carry out (C)
//   set_flags     instruction updates NZCV (ADDS/SUBS)
//   rd_in         destination register index
//   reg_write_in  instruction writes rd
//   flush         kill the held entry and refuse the incoming one
//   out_valid     registered entry valid toward MEM
//   out_ready     MEM accepts this cycle
//   result        registered sum
//   rd_out        registered destination index
//   reg_write_out registered write enable, forced to 0 while out_valid=0
//   flags         NZCV as {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu_result_stage #(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    sum,
  input  logic                overflow,
  input  logic                cout,
  input  logic                set_flags,
  input  logic [REG_BITS-1:0] rd_in,
  input  logic                reg_write_in,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic [REG_BITS-1:0] rd_out,
  output logic                reg_write_out,
  output logic [3:0]          flags
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic                reg_write_q, reg_write_d;
  logic [3:0]          flags_q, flags_d;

  logic                accept;
  logic                flag_update;
  logic [3:0]          nzcv_new;

  // NZCV of the instruction currently presented by EX.
  assign nzcv_new = {sum[WIDTH-1], (sum == '0), cout, overflow};

  // The ready term ignores flush. A flush blocks the capture but does not
  // change the handshake that EX sees.
  assign in_ready    = (state_q == EMPTY) | out_ready;
  assign accept      = in_valid & in_ready & ~flush;
  assign flag_update = accept & set_flags;

  // Next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    flags_d     = flags_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = FULL;
        // A drain with a simultaneous accept keeps the stage full.
        FULL:  if (out_ready && !accept) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end

    if (accept) begin
      result_d    = sum;
      rd_d        = rd_in;
      reg_write_d = reg_write_in;
    end

    if (flag_update) begin
      flags_d = nzcv_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      result_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid     = (state_q == FULL);
  assign result        = result_q;
  assign rd_out        = rd_q;
  // A stale write enable must never leak out of an empty stage.
  assign reg_write_out = reg_write_q & out_valid;

`ifdef FLAG_BYPASS_EN
  assign flags = flag_update ? nzcv_new : flags_q;
`else
  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] sum;
  logic        overflow;
  logic        cout;
  logic        set_flags;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic [3:0]  flags;

  int vectors;
  int miscompares;

  alu_result_stage #(.WIDTH(64), .REG_BITS(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sum           (sum),
    .overflow      (overflow),
    .cout          (cout),
    .set_flags     (set_flags),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .flags         (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] s, input logic ov, input logic co,
                       input logic sf, input logic [4:0] rd, input logic rw, input logic fl,
                       input logic ordy);
    in_valid     = v;
    sum          = s;
    overflow     = ov;
    cout         = co;
    set_flags    = sf;
    rd_in        = rd;
    reg_write_in = rw;
    flush        = fl;
    out_ready    = ordy;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) tick;
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_rd", {59'b0, rd_out}, 64'd0);
    chk("rst_rw", {63'b0, reg_write_out}, 64'd0);
    chk("rst_flags", {60'b0, flags}, 64'd0);
    chk("rst_ready", {63'b0, in_ready}, 64'd1);
    $display("step reset: valid=%0b result=%h flags=%b", out_valid, result, flags);

    // Test 1: load an entry, hold it, then reset in the middle of the hold
    reset_n = 1'b1;
    tick;
    drive(1'b1, 64'h1234, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick;
    chk("t1_valid", {63'b0, out_valid}, 64'd1);
    chk("t1_result", result, 64'h1234);
    chk("t1_rd", {59'b0, rd_out}, 64'd3);
    chk("t1_rw", {63'b0, reg_write_out}, 64'd1);
    in_valid = 1'b0;
    tick;
    chk("t1_hold", {63'b0, out_valid}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_valid", {63'b0, out_valid}, 64'd0);
    chk("t1_async_result", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    chk("t1_rel_valid", {63'b0, out_valid}, 64'd0);
    chk("t1_rel_result", result, 64'd0);
    chk("t1_rel_flags", {60'b0, flags}, 64'd0);
    $display("step t1: valid=%0b result=%h flags=%b", out_valid, result, flags);

    // Test 2: zero sum with carry sets flags to 0110
    drive(1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    #1;
`ifdef FLAG_BYPASS_EN
    chk("t2_bypass", {60'b0, flags}, 64'b0110);
`else
    chk("t2_pre_flags", {60'b0, flags}, 64'b0000);
`endif
    tick;
    chk("t2_valid", {63'b0, out_valid}, 64'd1);
    chk("t2_result", result, 64'd0);
    chk("t2_rd", {59'b0, rd_out}, 64'd5);
    in_valid = 1'b0;
    #1;
    chk("t2_flags", {60'b0, flags}, 64'b0110);
    $display("step t2: result=%h flags=%b", result, flags);

    // Test 3: negative with overflow, then a non-flag-setting op
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    tick;
    chk("t3a_valid", {63'b0, out_valid}, 64'd1);
    chk("t3a_result", result, 64'h8000_0000_0000_0000);
    chk("t3a_flags", {60'b0, flags}, 64'b1001);
    drive(1'b1, 64'd5, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1);
    tick;
    chk("t3b_result", result, 64'd5);
    chk("t3b_flags", {60'b0, flags}, 64'b1001);
    chk("t3b_rw", {63'b0, reg_write_out}, 64'd0);
    $display("step t3: result=%h flags=%b", result, flags);

    // Test 4: back-pressure for 3 cycles, then release with a new entry
    drive(1'b1, 64'h77, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_ready", {63'b0, in_ready}, 64'd0);
      tick;
      chk("t4_result", result, 64'd5);
      chk("t4_valid", {63'b0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_ready_rel", {63'b0, in_ready}, 64'd1);
    tick;
    chk("t4_new_result", result, 64'h77);
    chk("t4_new_valid", {63'b0, out_valid}, 64'd1);
    chk("t4_new_rd", {59'b0, rd_out}, 64'd7);
    $display("step t4: result=%h valid=%0b", result, out_valid);

    // Drain forces the write enable low
    in_valid = 1'b0;
    tick;
    chk("drain_valid", {63'b0, out_valid}, 64'd0);
    chk("drain_rw", {63'b0, reg_write_out}, 64'd0);
    $display("step drain: valid=%0b rw=%0b", out_valid, reg_write_out);

    // Test 5: flush beats a flag-setting incoming op
    drive(1'b1, 64'h99, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick;
    chk("t5_load", result, 64'h99);
    drive(1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0);
    #1;
    chk("t5_flush_comb_flags", {60'b0, flags}, 64'b1001);
    tick;
    chk("t5_valid", {63'b0, out_valid}, 64'd0);
    chk("t5_flags", {60'b0, flags}, 64'b1001);
    chk("t5_result", result, 64'h99);
    $display("step t5: valid=%0b flags=%b", out_valid, flags);

    // Test 6: all-ones sum, flag visibility timing
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
    #1;
`ifdef FLAG_BYPASS_EN
    chk("t6_same_cycle", {60'b0, flags}, 64'b1000);
`else
    chk("t6_same_cycle", {60'b0, flags}, 64'b1001);
`endif
    tick;
    in_valid = 1'b0;
    #1;
    chk("t6_next_flags", {60'b0, flags}, 64'b1000);
    chk("t6_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    $display("step t6: result=%h flags=%b", result, flags);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
